// File: rtl/nninterp_mc.sv
// Multi-channel nearest-neighbour rate converter driven by a shared phase accumulator.
// Define NNINTERP_MC_ROUND_EN to pick the nearer of the previous/current sample on each carry.
module nninterp_mc #(
  parameter int INW     = 16,
  parameter int NCHAN   = 2,
  parameter int CTRBITS = 32
) (
  input  logic                   i_clk,
  input  logic                   i_areset_n,
  input  logic                   i_ce,
  input  logic [CTRBITS-1:0]     i_step,
  input  logic                   i_sync,
  input  logic [NCHAN*INW-1:0]   i_data,
  output logic                   o_ce,
  output logic [NCHAN*INW-1:0]   o_data,
  output logic [CTRBITS-1:0]     o_phase
);

  typedef enum logic {
    EMPTY  = 1'b0,
    PRIMED = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CTRBITS-1:0]     counter_q, counter_d;
  logic                   ce_q, ce_d;
  logic [NCHAN*INW-1:0]   data_q, data_d;
  logic [CTRBITS-1:0]     phase_q, phase_d;

  logic [CTRBITS:0]       acc;
  logic                   carry;
  logic [CTRBITS-1:0]     sum;
  logic [NCHAN*INW-1:0]   sel_data;

  assign acc   = {1'b0, counter_q} + {1'b0, i_step};
  assign carry = acc[CTRBITS];
  assign sum   = acc[CTRBITS-1:0];

`ifdef NNINTERP_MC_ROUND_EN
  logic [NCHAN*INW-1:0]   prev_q, prev_d;

  // Upper half of the post-carry phase means the output instant lies closer to the older sample.
  genvar gi;
  generate
    for (gi = 0; gi < NCHAN; gi++) begin : g_lane
      assign sel_data[gi*INW +: INW] = (sum[CTRBITS-1] && (state_q == PRIMED))
                                       ? prev_q[gi*INW +: INW]
                                       : i_data[gi*INW +: INW];
    end
  endgenerate

  always_comb begin
    prev_d = prev_q;
    if (i_ce) prev_d = i_data;
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) prev_q <= '0;
    else             prev_q <= prev_d;
  end
`else
  assign sel_data = i_data;
`endif

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    ce_d      = 1'b0;
    data_d    = data_q;
    phase_d   = phase_q;
    if (i_ce) begin
      // The sync sample itself becomes valid history, so the lane is primed straight away.
      state_d = PRIMED;
      if (i_sync) begin
        counter_d = '0;
        ce_d      = 1'b1;
        data_d    = i_data;
        phase_d   = '0;
      end else begin
        counter_d = sum;
        if (carry) begin
          ce_d    = 1'b1;
          data_d  = sel_data;
          phase_d = sum;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q   <= EMPTY;
      counter_q <= '0;
      ce_q      <= 1'b0;
      data_q    <= '0;
      phase_q   <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      ce_q      <= ce_d;
      data_q    <= data_d;
      phase_q   <= phase_d;
    end
  end

  assign o_ce    = ce_q;
  assign o_data  = data_q;
  assign o_phase = phase_q;

endmodule

// File: tb/tb_nninterp_mc.sv
// Directed bench for nninterp_mc: vector table for a 2-lane instance plus hand sequences
// for asynchronous reset and a 4-lane instance.
module tb_nninterp_mc;

`ifdef NNINTERP_MC_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        i_ce, i_sync;
  logic [31:0] i_step;
  logic [31:0] i_data;
  logic        o_ce;
  logic [31:0] o_data;
  logic [31:0] o_phase;

  logic        c4_ce, c4_sync;
  logic [31:0] c4_step;
  logic [63:0] c4_data;
  logic        c4_oce;
  logic [63:0] c4_odata;
  logic [31:0] c4_ophase;

  int checks = 0;
  int errors = 0;

  nninterp_mc #(.INW(16), .NCHAN(2), .CTRBITS(32)) u_dut (
    .i_clk(clk), .i_areset_n(rst_n), .i_ce(i_ce), .i_step(i_step), .i_sync(i_sync),
    .i_data(i_data), .o_ce(o_ce), .o_data(o_data), .o_phase(o_phase)
  );

  nninterp_mc #(.INW(16), .NCHAN(4), .CTRBITS(32)) u_dut4 (
    .i_clk(clk), .i_areset_n(rst_n), .i_ce(c4_ce), .i_step(c4_step), .i_sync(c4_sync),
    .i_data(c4_data), .o_ce(c4_oce), .o_data(c4_odata), .o_phase(c4_ophase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic        sync;
    logic [31:0] step;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        ece;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [31:0] eph;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic ce, logic sync, logic [31:0] step, logic [15:0] d0,
                              logic [15:0] d1, logic ece, logic [15:0] e0, logic [15:0] e1,
                              logic [31:0] eph);
    vec_t v;
    v.ce = ce; v.sync = sync; v.step = step; v.d0 = d0; v.d1 = d1;
    v.ece = ece; v.e0 = e0; v.e1 = e1; v.eph = eph;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] r0, r1;
    logic [63:0] exp4;
    i_ce = 0; i_sync = 0; i_step = 0; i_data = 0;
    c4_ce = 0; c4_sync = 0; c4_step = 0; c4_data = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ce", {63'd0, o_ce}, 64'd0);
    check("reset_data", {32'd0, o_data}, 64'd0);
    check("reset_phase", {32'd0, o_phase}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    #1;

    // Quarter step: carry on every 4th strobe, lanes hold between strobes.
    for (int n = 0; n < 8; n++) begin
      logic hit;
      logic [15:0] hd;
      hit = (n % 4) == 3;
      hd  = (n < 3) ? 16'd0 : ((n < 7) ? 16'd3 : 16'd7);
      vt.push_back(mk(1, 0, 32'h4000_0000, 16'(n), 16'(n + 100), hit, hd,
                      (n < 3) ? 16'd0 : hd + 16'd100, 32'h0));
    end
    // Zero step never carries.
    vt.push_back(mk(1, 0, 32'h0, 16'd90, 16'd91, 0, 16'd7, 16'd107, 32'h0));
    vt.push_back(mk(1, 0, 32'h0, 16'd92, 16'd93, 0, 16'd7, 16'd107, 32'h0));
    // Sync realigns, then three-quarter step.
    vt.push_back(mk(1, 1, 32'hC000_0000, 16'd5, 16'd500, 1, 16'd5, 16'd500, 32'h0));
    vt.push_back(mk(1, 0, 32'hC000_0000, 16'd10, 16'd1010, 0, 16'd5, 16'd500, 32'h0));
    vt.push_back(mk(1, 0, 32'hC000_0000, 16'd20, 16'd1020, 1,
                    ROUND ? 16'd10 : 16'd20, ROUND ? 16'd1010 : 16'd1020, 32'h8000_0000));
    vt.push_back(mk(1, 0, 32'hC000_0000, 16'd30, 16'd1030, 1, 16'd30, 16'd1030, 32'h4000_0000));
    vt.push_back(mk(1, 0, 32'hC000_0000, 16'd40, 16'd1040, 1, 16'd40, 16'd1040, 32'h0));
    // Sync mid-stream, with an idle gap and a stray sync without strobe.
    vt.push_back(mk(1, 0, 32'h4000_0000, 16'd50, 16'd150, 0, 16'd40, 16'd1040, 32'h0));
    vt.push_back(mk(1, 0, 32'h4000_0000, 16'd51, 16'd151, 0, 16'd40, 16'd1040, 32'h0));
    vt.push_back(mk(0, 0, 32'h4000_0000, 16'd99, 16'd99, 0, 16'd40, 16'd1040, 32'h0));
    vt.push_back(mk(1, 1, 32'h4000_0000, 16'd52, 16'd152, 1, 16'd52, 16'd152, 32'h0));
    vt.push_back(mk(1, 0, 32'h4000_0000, 16'd53, 16'd153, 0, 16'd52, 16'd152, 32'h0));
    vt.push_back(mk(1, 0, 32'h4000_0000, 16'd54, 16'd154, 0, 16'd52, 16'd152, 32'h0));
    vt.push_back(mk(0, 1, 32'h4000_0000, 16'd98, 16'd98, 0, 16'd52, 16'd152, 32'h0));
    vt.push_back(mk(1, 0, 32'h4000_0000, 16'd55, 16'd155, 0, 16'd52, 16'd152, 32'h0));
    vt.push_back(mk(1, 0, 32'h4000_0000, 16'd56, 16'd156, 1, 16'd56, 16'd156, 32'h0));
    // Sync wins over a simultaneous carry.
    vt.push_back(mk(1, 0, 32'hC000_0000, 16'd60, 16'd160, 0, 16'd56, 16'd156, 32'h0));
    vt.push_back(mk(1, 1, 32'hC000_0000, 16'd61, 16'd161, 1, 16'd61, 16'd161, 32'h0));
    vt.push_back(mk(0, 0, 32'hC000_0000, 16'd62, 16'd162, 0, 16'd61, 16'd161, 32'h0));

    for (int i = 0; i < vt.size(); i++) begin
      i_ce = vt[i].ce; i_sync = vt[i].sync; i_step = vt[i].step;
      i_data = {vt[i].d1, vt[i].d0};
      tick();
      i_ce = 0; i_sync = 0;
      $display("vec %0d ce=%b sync=%b step=%h -> o_ce=%b o_data=%h o_phase=%h",
               i, vt[i].ce, vt[i].sync, vt[i].step, o_ce, o_data, o_phase);
      check($sformatf("vec%0d_ce", i), {63'd0, o_ce}, {63'd0, vt[i].ece});
      check($sformatf("vec%0d_data", i), {32'd0, o_data}, {32'd0, vt[i].e1, vt[i].e0});
      check($sformatf("vec%0d_phase", i), {32'd0, o_phase}, {32'd0, vt[i].eph});
    end

    // Asynchronous reset mid-stream discards history.
    i_ce = 1; i_step = 32'h8000_0000; i_data = {16'd180, 16'd80};
    tick();
    tick();
    i_ce = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    check("arst_ce", {63'd0, o_ce}, 64'd0);
    check("arst_data", {32'd0, o_data}, 64'd0);
    check("arst_phase", {32'd0, o_phase}, 64'd0);
    tick();
    check("arst_hold_data", {32'd0, o_data}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    i_ce = 1; i_step = 32'hFFFF_FFFF; i_data = {16'd170, 16'd70};
    tick();
    $display("post-reset strobe 1 -> o_ce=%b o_data=%h o_phase=%h", o_ce, o_data, o_phase);
    check("prst1_ce", {63'd0, o_ce}, 64'd0);
    check("prst1_data", {32'd0, o_data}, 64'd0);
    i_data = {16'd171, 16'd71};
    tick();
    i_ce = 0;
    $display("post-reset strobe 2 -> o_ce=%b o_data=%h o_phase=%h", o_ce, o_data, o_phase);
    r0 = ROUND ? 16'd70 : 16'd71;
    r1 = ROUND ? 16'd170 : 16'd171;
    check("prst2_ce", {63'd0, o_ce}, 64'd1);
    check("prst2_data", {32'd0, o_data}, {32'd0, r1, r0});
    check("prst2_phase", {32'd0, o_phase}, {32'd0, 32'hFFFF_FFFE});
    tick();
    check("prst_idle_ce", {63'd0, o_ce}, 64'd0);

    // Four lanes with distinct ramps at half step.
    exp4 = 64'd0;
    for (int n = 0; n < 6; n++) begin
      logic [63:0] din;
      for (int k = 0; k < 4; k++) din[k*16 +: 16] = 16'((k + 1) * 16'h1000 + n);
      c4_ce = 1; c4_step = 32'h8000_0000; c4_data = din;
      if (n % 2 == 1) exp4 = din;
      tick();
      c4_ce = 0;
      $display("lane4 strobe %0d -> o_ce=%b o_data=%h", n, c4_oce, c4_odata);
      check($sformatf("lane4_%0d_ce", n), {63'd0, c4_oce}, {63'd0, 1'(n % 2)});
      check($sformatf("lane4_%0d_data", n), c4_odata, exp4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
